// File: rtl/datapath_seq.sv
`default_nettype none
// ============================================================================
// Module   : datapath_seq
// Purpose  : Sequential ALU with a valid/ready handshake on both sides.
//            Single-cycle add/sub/logic ops; shift-add multiply taking one
//            multiplier bit per cycle (N cycles). The result is held until
//            the consumer takes it.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            A, B            - signed N-bit operands
//            opcode          - 000 add, 001 sub, 010 and, 011 or, 100 xor,
//                              101 not A, 110 multiply, 111 pass B
//            in_valid/in_ready   - request handshake (ready only when idle)
//            Y, co               - registered result and carry/overflow flag
//            out_valid/out_ready - result handshake
// Config   : `define DATAPATH_SAT_EN to saturate add/sub on signed overflow
//            (co then reports signed overflow). Undefined: results wrap.
// Revision : 1.0 - initial release
// ============================================================================
module datapath_seq #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [2:0]   opcode,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] Y,
    output logic         co,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int         CW      = (N > 1) ? $clog2(N) : 1;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MUL   = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [2:0] c_op_add  = 3'b000;
    localparam logic [2:0] c_op_sub  = 3'b001;
    localparam logic [2:0] c_op_and  = 3'b010;
    localparam logic [2:0] c_op_or   = 3'b011;
    localparam logic [2:0] c_op_xor  = 3'b100;
    localparam logic [2:0] c_op_not  = 3'b101;
    localparam logic [2:0] c_op_mul  = 3'b110;
    localparam logic [2:0] c_op_pass = 3'b111;
    localparam logic [CW-1:0] c_last_bit = CW'(N - 1);

    logic [1:0]     r_state;
    logic [N-1:0]   r_y;
    logic           r_co;
    logic           r_out_valid;
    logic [2*N-1:0] r_mcand;   // multiplicand, shifted left each MUL cycle
    logic [N-1:0]   r_mplier;  // multiplier, shifted right each MUL cycle
    logic [2*N-1:0] r_acc;     // partial product
    logic [CW-1:0]  r_cnt;

    logic           w_is_sub;
    logic [N-1:0]   w_bop;
    logic [N:0]     w_sum;
    logic [N-1:0]   w_y;
    logic           w_co;
    logic [2*N-1:0] w_acc_next;

`ifdef DATAPATH_SAT_EN
    localparam logic [N-1:0] c_sat_max = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] c_sat_min = {1'b1, {(N-1){1'b0}}};
    logic w_ovf;
`endif

    // Subtraction is A + ~B + 1, so the carry out is the "no borrow" flag.
    always_comb begin
        w_is_sub = (opcode == c_op_sub);
        w_bop    = w_is_sub ? ~B : B;
        w_sum    = {1'b0, A} + {1'b0, w_bop} + {{N{1'b0}}, w_is_sub};
`ifdef DATAPATH_SAT_EN
        // Overflow: both addends share a sign that the result does not.
        w_ovf    = (A[N-1] == w_bop[N-1]) && (w_sum[N-1] != A[N-1]);
`endif
        w_y      = '0;
        w_co     = 1'b0;
        case (opcode)
            c_op_add, c_op_sub: begin
`ifdef DATAPATH_SAT_EN
                w_y  = w_ovf ? (A[N-1] ? c_sat_min : c_sat_max) : w_sum[N-1:0];
                w_co = w_ovf;
`else
                w_y  = w_sum[N-1:0];
                w_co = w_sum[N];
`endif
            end
            c_op_and:  w_y = A & B;
            c_op_or:   w_y = A | B;
            c_op_xor:  w_y = A ^ B;
            c_op_not:  w_y = ~A;
            c_op_pass: w_y = B;
            default:   w_y = '0;   // multiply is produced by the MUL state
        endcase
    end

    // Unsigned shift-add step; the low N bits match the signed product and
    // the high N bits feed the overflow flag.
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_y         <= '0;
            r_co        <= 1'b0;
            r_out_valid <= 1'b0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (opcode == c_op_mul) begin
                            r_mcand  <= {{N{1'b0}}, A};
                            r_mplier <= B;
                            r_acc    <= '0;
                            r_cnt    <= '0;
                            r_state  <= S_MUL;
                        end else begin
                            r_y         <= w_y;
                            r_co        <= w_co;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == c_last_bit) begin
                        r_y         <= w_acc_next[N-1:0];
                        r_co        <= |w_acc_next[2*N-1:N];
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Returning to IDLE here means a new request can only be
                    // taken on the following edge.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign Y         = r_y;
    assign co        = r_co;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_datapath_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_datapath_seq
// Purpose  : Directed, table-driven self-checking bench for datapath_seq
//            (N = 16), plus hand-written backpressure, overlap and reset
//            sequences. Latency counts edges from the accept edge inclusive.
// Revision : 1.0 - initial release
// ============================================================================
module tb_datapath_seq;

    localparam int N = 16;

    logic         clk;
    logic         rst;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [2:0]   opcode;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] Y;
    logic         co;
    logic         out_valid;
    logic         out_ready;

    int checks;
    int failures;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [2:0]   op;
        logic [N-1:0] y;
        logic         co;
        int           lat;
    } vec_t;

    vec_t vecs[16];

    datapath_seq #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .opcode    (opcode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Y         (Y),
        .co        (co),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    endtask

    // Apply one request, measure latency, check result, then release it.
    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        string tag;
        tag = $sformatf("vec%0d", idx);
        wait_ready();
        A = v.a; B = v.b; opcode = v.op; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(v.lat));
        chk({tag, "_y"}, 32'(Y), 32'(v.y));
        chk({tag, "_co"}, 32'(co), 32'(v.co));
        chk({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_release_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_release_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; A = '0; B = '0; opcode = '0; in_valid = 1'b0; out_ready = 1'b0;

        vecs[0]  = '{16'd100,  16'hFFE2, 3'b000, 16'h0046, 1'b1, 1};
`ifdef DATAPATH_SAT_EN
        vecs[1]  = '{16'h7FFF, 16'h0001, 3'b000, 16'h7FFF, 1'b1, 1};
        vecs[2]  = '{16'h8000, 16'h0001, 3'b001, 16'h8000, 1'b1, 1};
        vecs[3]  = '{16'hFFFF, 16'h0001, 3'b000, 16'h0000, 1'b0, 1};
        vecs[4]  = '{16'h8000, 16'hFFFF, 3'b000, 16'h8000, 1'b1, 1};
`else
        vecs[1]  = '{16'h7FFF, 16'h0001, 3'b000, 16'h8000, 1'b0, 1};
        vecs[2]  = '{16'h8000, 16'h0001, 3'b001, 16'h7FFF, 1'b1, 1};
        vecs[3]  = '{16'hFFFF, 16'h0001, 3'b000, 16'h0000, 1'b1, 1};
        vecs[4]  = '{16'h8000, 16'hFFFF, 3'b000, 16'h7FFF, 1'b1, 1};
`endif
        vecs[5]  = '{16'd5,    16'd7,    3'b001, 16'hFFFE, 1'b0, 1};
        vecs[6]  = '{16'd7,    16'd5,    3'b001, 16'h0002, 1'b1, 1};
        vecs[7]  = '{16'h00F0, 16'h0F0F, 3'b010, 16'h0000, 1'b0, 1};
        vecs[8]  = '{16'h00F0, 16'h0F0F, 3'b011, 16'h0FFF, 1'b0, 1};
        vecs[9]  = '{16'h00F0, 16'h0F0F, 3'b100, 16'h0FFF, 1'b0, 1};
        vecs[10] = '{16'h00F0, 16'h0F0F, 3'b101, 16'hFF0F, 1'b0, 1};
        vecs[11] = '{16'h00F0, 16'h0F0F, 3'b111, 16'h0F0F, 1'b0, 1};
        vecs[12] = '{16'd300,  16'hFFFE, 3'b110, 16'hFDA8, 1'b1, 17};
        vecs[13] = '{16'd200,  16'd300,  3'b110, 16'hEA60, 1'b0, 17};
        vecs[14] = '{16'hFFFF, 16'hFFFF, 3'b110, 16'h0001, 1'b1, 17};
        vecs[15] = '{16'd7,    16'd0,    3'b110, 16'h0000, 1'b0, 17};

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_y", 32'(Y), 32'd0);
        chk("reset_co", 32'(co), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

        // Backpressure: result held, new requests ignored while DONE
        wait_ready();
        A = 16'd5; B = 16'd7; opcode = 3'b001; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        A = 16'd1; B = 16'd1; opcode = 3'b000;   // must be ignored
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("bp%0d_y", i), 32'(Y), 32'h0000FFFE);
            chk($sformatf("bp%0d_co", i), 32'(co), 32'd0);
            chk($sformatf("bp%0d_in_ready", i), 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        // Release with in_valid still high: no overlap on the release edge
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("overlap_valid", 32'(out_valid), 32'd0);
        chk("overlap_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;       // now 1 + 1 is accepted
        in_valid = 1'b0;
        chk("overlap_next_valid", 32'(out_valid), 32'd1);
        chk("overlap_next_y", 32'(Y), 32'd2);
        chk("overlap_next_co", 32'(co), 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset on the 8th MUL cycle
        wait_ready();
        A = 16'd300; B = 16'hFFFE; opcode = 3'b110; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mulrst_valid", 32'(out_valid), 32'd0);
        chk("mulrst_y", 32'(Y), 32'd0);
        chk("mulrst_co", 32'(co), 32'd0);
        chk("mulrst_in_ready", 32'(in_ready), 32'd1);
        repeat (20) @(posedge clk);
        #1 chk("mulrst_no_result", 32'(out_valid), 32'd0);
        run_vec(vecs[13], 13);

        // Reset in DONE wins over simultaneous out_ready/in_valid
        wait_ready();
        A = 16'd9; B = 16'd3; opcode = 3'b000; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("donerst_pre_valid", 32'(out_valid), 32'd1);
        rst = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        chk("donerst_valid", 32'(out_valid), 32'd0);
        chk("donerst_y", 32'(Y), 32'd0);
        chk("donerst_in_ready", 32'(in_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/datapath_seq.md
DATAPATH_SEQ -- requirements
Module: datapath_seq

Interface
REQ-001 SHALL have parameter N, default 16, meaning operand/result width in bits (N >= 4).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port A, input, N, signed operand A.
REQ-005 SHALL have port B, input, N, signed operand B.
REQ-006 SHALL have port opcode, input, 3, operation select.
REQ-007 SHALL have port in_valid, input, 1, operands/opcode valid.
REQ-008 SHALL have port in_ready, output, 1, block can accept a request.
REQ-009 SHALL have port Y, output, N, signed registered result.
REQ-010 SHALL have port co, output, 1, registered carry/overflow flag.
REQ-011 SHALL have port out_valid, output, 1, Y/co valid.
REQ-012 SHALL have port out_ready, input, 1, consumer takes result.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, DONE; in_ready = 1 only in IDLE.
REQ-014 SHALL accept a request on a rising edge with in_valid && in_ready, latching A, B, opcode.
REQ-015 SHALL decode opcode: 000 A+B, 001 A-B, 010 A&B, 011 A|B, 100 A^B, 101 ~A, 110 A*B, 111 pass B.
REQ-016 SHALL, for opcodes other than 110, go IDLE->DONE at the accept edge with Y/co registered; out_valid high the cycle after accept (latency 1).
REQ-017 SHALL, for 110, go IDLE->MUL and perform shift-add multiply, one multiplier bit per cycle, exactly N cycles in MUL, then enter DONE; out_valid after N+1 edges from accept.
REQ-018 SHALL give Y = low N bits of product for 110 (identical for signed and unsigned); co = 1 iff high N bits of the unsigned 2N-bit product are non-zero.
REQ-019 SHALL set co for 000 to carry out of bit N-1; for 001 to carry out of A + ~B + 1 (1 = no borrow); co = 0 for 010,011,100,101,111.
REQ-020 SHALL hold Y, co, out_valid stable in DONE until out_ready = 1; on that edge return to IDLE and clear out_valid.
REQ-021 SHALL ignore in_valid outside IDLE; a request arriving with out_ready high in DONE is accepted no earlier than the next cycle (no overlap).
REQ-022 SHALL wrap add/sub results modulo 2^N when DATAPATH_SAT_EN is undefined.

Reset
REQ-023 SHALL on rst = 1 at a rising edge enter IDLE, set Y = 0, co = 0, out_valid = 0, in_ready = 1 next cycle.
REQ-024 SHALL abort an in-progress multiply or pending DONE on reset, discarding the result.
REQ-025 SHALL give rst priority over any simultaneous in_valid/out_ready.

Configuration
REQ-026 SHALL, with macro DATAPATH_SAT_EN defined, saturate 000/001 on signed overflow to 2^(N-1)-1 or -2^(N-1), with co = 1 iff signed overflow occurred.
REQ-027 SHALL, without DATAPATH_SAT_EN, behave per REQ-019/REQ-022 with no saturation logic synthesised; other opcodes unaffected either way.

Verification (N = 16)
REQ-028 Add: A=100, B=-30, op=000, out_ready=1 -> next cycle out_valid=1, Y=70, co=1.
REQ-029 Wrap vs sat: A=32767, B=1, op=000 -> without DATAPATH_SAT_EN Y=-32768, co=0; with it Y=32767, co=1.
REQ-030 Multiply: A=300, B=-2, op=110 -> out_valid exactly 17 edges after accept, Y=-600, co=1; A=200, B=300 -> Y=-5536, co=0.
REQ-031 Backpressure: op=001, A=5, B=7, out_ready=0 for 5 cycles -> Y=-2, co=0 held, in_ready=0 throughout; out_ready=1 -> IDLE next edge.
REQ-032 Reset mid-multiply: assert rst at 8th MUL cycle -> next cycle out_valid=0, Y=0, co=0, in_ready=1; fresh request then completes correctly.
REQ-033 Logic ops: A=16'h00F0, B=16'h0F0F, ops 010/011/100/101/111 -> Y=16'h0000/16'h0FFF/16'h0FFF/16'hFF0F/16'h0F0F, co=0.
